// File: rtl/tm_pkg.sv
// Shared types for the Turing-machine engine: control states, head direction
// and the decoded rule record.
package tm_pkg;

  localparam int MAX_SW = 8;
  localparam int MAX_QW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_t;

  typedef enum logic {
    L = 1'b0,
    R = 1'b1
  } dir_t;

  // Fields are sized for the largest supported machine; narrower builds zero-extend.
  typedef struct packed {
    logic [MAX_SW-1:0] write_sym;
    dir_t              dir;
    logic [MAX_QW-1:0] next_state;
    logic              halt;
  } rule_t;

endpackage

// File: rtl/tm_if.sv
// Configuration, control and status bundle of the Turing-machine engine.
interface tm_if #(
  parameter int NSTATES    = 2,
  parameter int NSYMS      = 5,
  parameter int TAPE_DEPTH = 64,
  parameter int CNT_W      = 40
);
  localparam int SW = $clog2(NSYMS);
  localparam int QW = $clog2(NSTATES);
  localparam int PW = $clog2(TAPE_DEPTH);
  localparam int AW = $clog2(NSTATES * NSYMS);

  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [SW+QW+1:0]    cfg_data;
  logic                start;
  logic                abort;
  logic                busy;
  logic                halted;
  logic                error;
  logic [CNT_W-1:0]    steps;
  logic [CNT_W-1:0]    ones;
  logic [PW-1:0]       pos;
  logic [QW-1:0]       cur_state;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, abort,
    input  busy, halted, error, steps, ones, pos, cur_state
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, abort,
    output busy, halted, error, steps, ones, pos, cur_state
  );

endinterface

// File: rtl/tm_tape_ram.sv
// Single-port tape store: synchronous write, combinational read of the
// addressed cell so the engine can read-modify-write one cell per cycle.
module tm_tape_ram #(
  parameter int DEPTH = 64,
  parameter int SW    = 3
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [SW-1:0]            wdata,
  output logic [SW-1:0]            rdata
);

  logic [SW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/tm_engine.sv
// Turing-machine engine: loads a rule table, clears the tape, then runs one
// transition per cycle until halt, head overrun, counter saturation or abort.
module tm_engine
  import tm_pkg::*;
#(
  parameter int NSTATES    = 2,
  parameter int NSYMS      = 5,
  parameter int TAPE_DEPTH = 64,
  parameter int CNT_W      = 40
) (
  input logic CLK_66MHZ,
  input logic RESET_N,
  tm_if.slave bus
);

  localparam int SW     = $clog2(NSYMS);
  localparam int QW     = $clog2(NSTATES);
  localparam int PW     = $clog2(TAPE_DEPTH);
  localparam int NRULES = NSTATES * NSYMS;
  localparam int AW     = $clog2(NRULES);
  localparam int RW     = SW + QW + 2;
  localparam int IW     = SW + QW + 1;

  ctrl_state_t      state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [QW-1:0]    cur_state_q, cur_state_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             halted_q, halted_d;
  logic             error_q, error_d;

  logic [RW-1:0]    rule_mem [NRULES];
  logic             cfg_open;

  logic             tape_we;
  logic [SW-1:0]    tape_wdata;
  logic [SW-1:0]    rd_sym;

  logic [IW-1:0]    idx;
  logic             sym_bad, idx_bad, at_edge;
  rule_t            rule;
  logic [SW-1:0]    wsym;
  logic [CNT_W-1:0] steps_inc, ones_upd;
  logic             unused_bits;

  function automatic rule_t unpack_rule(input logic [RW-1:0] raw);
    rule_t r;
    r            = '0;
    r.write_sym  = MAX_SW'(raw[RW-1 -: SW]);
    r.dir        = raw[QW+1] ? R : L;
    r.next_state = MAX_QW'(raw[QW:1]);
    r.halt       = raw[0];
    return r;
  endfunction

  // Rules may only change while no run is in flight.
  assign cfg_open = (state_q == ST_IDLE) || (state_q == ST_DONE);

  always_ff @(posedge CLK_66MHZ) begin
    for (int i = 0; i < NRULES; i++) begin
      if (bus.cfg_we && cfg_open && (bus.cfg_addr == AW'(i))) begin
        rule_mem[i] <= bus.cfg_data;
      end
    end
  end

  tm_tape_ram #(
    .DEPTH (TAPE_DEPTH),
    .SW    (SW)
  ) u_tape (
    .clk   (CLK_66MHZ),
    .we    (tape_we),
    .addr  (pos_q),
    .wdata (tape_wdata),
    .rdata (rd_sym)
  );

  assign idx       = IW'(cur_state_q) * IW'(NSYMS) + IW'(rd_sym);
  assign sym_bad   = ({1'b0, rd_sym} >= (SW+1)'(NSYMS));
  assign idx_bad   = (idx >= IW'(NRULES));
  assign rule      = idx_bad ? rule_t'('0) : unpack_rule(rule_mem[idx[AW-1:0]]);
  assign wsym      = rule.write_sym[SW-1:0];
  assign at_edge   = ((rule.dir == L) && (pos_q == '0)) || ((rule.dir == R) && (&pos_q));
  assign steps_inc = steps_q + CNT_W'(1);
  assign ones_upd  = ((rd_sym == '0) && (wsym != '0)) ? ones_q + CNT_W'(1) :
                     ((rd_sym != '0) && (wsym == '0)) ? ones_q - CNT_W'(1) : ones_q;
  assign unused_bits = ^{rule, idx};

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    cur_state_d = cur_state_q;
    steps_d     = steps_q;
    ones_d      = ones_q;
    halted_d    = halted_q;
    error_d     = error_q;
    tape_we     = 1'b0;
    tape_wdata  = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d  = ST_CLEAR;
          pos_d    = '0;
          steps_d  = '0;
          ones_d   = '0;
          halted_d = 1'b0;
          error_d  = 1'b0;
        end
      end

      ST_CLEAR: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          tape_we = 1'b1;
          if (&pos_q) begin
            state_d     = ST_RUN;
            pos_d       = PW'(TAPE_DEPTH / 2);
            cur_state_d = '0;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (sym_bad || idx_bad) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end else begin
          tape_we    = 1'b1;
          tape_wdata = wsym;
          steps_d    = steps_inc;
          ones_d     = ones_upd;
          if (rule.halt) begin
            state_d  = ST_DONE;
            halted_d = 1'b1;
          end else if (at_edge) begin
            state_d = ST_DONE;
            error_d = 1'b1;
          end else begin
            pos_d       = (rule.dir == R) ? pos_q + PW'(1) : pos_q - PW'(1);
            cur_state_d = rule.next_state[QW-1:0];
          end
          // Stop before the step counter could ever wrap.
          if (&steps_inc) begin
            state_d = ST_DONE;
            error_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_66MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      cur_state_q <= '0;
      steps_q     <= '0;
      ones_q      <= '0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      cur_state_q <= cur_state_d;
      steps_q     <= steps_d;
      ones_q      <= ones_d;
      halted_q    <= halted_d;
      error_q     <= error_d;
    end
  end

  assign bus.busy      = (state_q == ST_CLEAR) || (state_q == ST_RUN);
  assign bus.halted    = halted_q;
  assign bus.error     = error_q;
  assign bus.steps     = steps_q;
  assign bus.ones      = ones_q;
  assign bus.pos       = pos_q;
  assign bus.cur_state = cur_state_q;

endmodule

// File: doc/tm_engine.md
TM_ENGINE -- requirements
Module: tm_engine

Interface
REQ-001 Parameters SHALL be: NSTATES, default 2, number of machine states; NSYMS, default 5, tape alphabet size; TAPE_DEPTH, default 64, tape cells, power of 2; CNT_W, default 40, step/ones counter width.
REQ-002 Derived widths SHALL be: SW=$clog2(NSYMS), QW=$clog2(NSTATES), PW=$clog2(TAPE_DEPTH), AW=$clog2(NSTATES*NSYMS).
REQ-003 Ports SHALL be (name  direction  width  meaning):
  CLK_66MHZ  in  1  sole clock, rising edge
  RESET_N  in  1  reset, asynchronous, active-low
  cfg_we  in  1  rule-table write strobe
  cfg_addr  in  AW  rule index = state*NSYMS + symbol
  cfg_data  in  SW+1+QW+1  {write_sym, dir (0=L,1=R), next_state, halt}
  start  in  1  begin run, level-sampled
  abort  in  1  stop run, return to IDLE
  busy  out  1  high in CLEAR or RUN
  halted  out  1  high in DONE after halt rule
  error  out  1  high in DONE after tape/counter overflow
  steps  out  CNT_W  transitions executed
  ones  out  CNT_W  count of non-zero tape cells
  pos  out  PW  current head position
  cur_state  out  QW  current machine state

Function
REQ-004 Control FSM SHALL have states IDLE, CLEAR, RUN, DONE.
REQ-005 IDLE: start=1 SHALL enter CLEAR next cycle with pos=0, steps=0, ones=0, halted=0, error=0.
REQ-006 CLEAR SHALL write 0 to tape[pos] each cycle, increment pos, and after cell TAPE_DEPTH-1 enter RUN with pos=TAPE_DEPTH/2, cur_state=0 (CLEAR lasts exactly TAPE_DEPTH cycles).
REQ-007 RUN SHALL execute one transition per cycle: rule=table[cur_state*NSYMS+tape[pos]]; write write_sym to tape[pos]; steps+1.
REQ-008 Non-halt rule SHALL move pos by ±1 per dir and load cur_state=next_state.
REQ-009 Halt rule SHALL write its symbol, count the step, leave pos and cur_state unchanged, enter DONE, set halted=1.
REQ-010 Head at pos=0 with dir=L, or pos=TAPE_DEPTH-1 with dir=R, SHALL write, count the step, keep pos, enter DONE, set error=1.
REQ-011 steps reaching all-ones SHALL enter DONE with error=1; counters SHALL never wrap.
REQ-012 ones SHALL update in the same cycle as each write: +1 if old=0 and new≠0, −1 if old≠0 and new=0, else unchanged.
REQ-013 Rule index ≥ NSTATES*NSYMS or read symbol ≥ NSYMS SHALL enter DONE with error=1, no write, no step.
REQ-014 DONE SHALL hold all outputs; start=1 SHALL re-enter CLEAR per REQ-005.
REQ-015 abort=1 in CLEAR or RUN SHALL enter IDLE next cycle, counters held; abort SHALL take priority over halt/error in the same cycle.
REQ-016 cfg_we SHALL write the rule table only in IDLE or DONE; writes in CLEAR/RUN SHALL be ignored.
REQ-017 busy SHALL be combinational from FSM state; all other outputs SHALL be registered.

Reset
REQ-018 RESET_N low SHALL asynchronously force IDLE, pos=0, cur_state=0, steps=0, ones=0, busy=0, halted=0, error=0.
REQ-019 Tape and rule-table contents SHALL be undefined after reset; rules SHALL be reloaded, tape is cleared by CLEAR.
REQ-020 Reset asserted mid-RUN SHALL abandon the run with no further tape writes.

Structure
REQ-021 Package tm_pkg SHALL hold: ctrl_state_t enum, dir_t enum {L,R}, rule_t packed struct {write_sym, dir, next_state, halt}.
REQ-022 Tape SHALL be sub-module tm_tape_ram: single-port, synchronous write, asynchronous read, parametrised by depth and SW.
REQ-023 Rule table SHALL be a register array local to tm_engine.

Verification
REQ-024 BB(2,2) defaults NSYMS=2: rules 1RB 1LB / 1LA 1RH, start -> halted=1, steps=6, ones=4, error=0.
REQ-025 Single rule A0=1RA, TAPE_DEPTH=64 -> error=1, halted=0, steps=32, ones=32, pos=63.
REQ-026 BB(2,2) with abort pulsed at RUN step 3 -> IDLE, busy=0, steps=3; then start -> full rerun gives steps=6, ones=4.
REQ-027 cfg_we during RUN changing A0 -> run result unchanged (steps=6, ones=4).
REQ-028 RESET_N low mid-RUN -> all outputs zero immediately, IDLE; start -> clean rerun steps=6.
REQ-029 CLEAR after prior run leaving ones=4 -> every cell reads 0, ones=0, RUN entered after exactly TAPE_DEPTH cycles.
